// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings for MULT/MULTU/DIV/DIVU
//   - FSM state enum
//   - small op-decode helpers
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration of the multiply/divide datapath.
// Ports:
//   div      in   1       1 = restoring divide step, 0 = shift-add multiply step
//   acc      in   2*XLEN  accumulator {upper, lower}
//   opnd     in   XLEN    multiplicand (multiply) or divisor (divide)
//   acc_nxt  out  2*XLEN  accumulator after this step (divide: LSB left 0)
//   qbit     out  1       quotient bit produced by a divide step (0 for multiply)
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              qbit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  always_comb begin
    acc_nxt = '0;
    qbit    = 1'b0;
    // Multiply: lower half holds the remaining multiplier bits, upper half the
    // partial product; the carry out of the add shifts into the upper half.
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
    // Divide: remainder shifted left by one with the next dividend bit; since
    // the remainder is always below the divisor, a set MSB means "borrow".
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (div) begin
      qbit = ~trial[XLEN];
      if (qbit) begin
        acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One radix-2 step per cycle; start/busy/done handshake plus abort for flushes.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op, a, b    launch request (accepted when not busy), opcode, operands
//   mthi, mtlo         write a into HI / LO while not busy
//   abort              kill the in-flight operation (suppresses a same-cycle start)
//   busy, done         RUN/FIX indication, one-cycle completion pulse
//   div_by_zero        set for DIV/DIVU with b=0, held until the next accepted start
//   hi, lo             HI/LO registers
// Optional build macro MDU_ZERO_SKIP_EN: operations with a=0 or b=0 bypass RUN.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo allowed
// RUN   | one iteration per cycle, counter counts down to 1
// FIX   | apply result signs, HI/LO written on exit
// DONE  | done pulse; a new start may be accepted here
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t state, state_nxt;

  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd, a_orig, abs_a, abs_b, res_hi, res_lo;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, res_neg, rem_neg, dz_q, qbit;
  logic              sgn_a, sgn_b, accept, zero_go;

  assign sgn_a = op_is_signed(op) & a[XLEN-1];
  assign sgn_b = op_is_signed(op) & b[XLEN-1];
  assign abs_a = sgn_a ? -a : a;
  assign abs_b = sgn_b ? -b : b;

  assign accept = start && !abort && ((state == S_IDLE) || (state == S_DONE));

`ifdef MDU_ZERO_SKIP_EN
  assign zero_go = (a == '0) || (b == '0);
`else
  assign zero_go = 1'b0;
`endif

  assign div_by_zero = dz_q;

  mdu_step #(.XLEN(XLEN)) u_step (
    .div     (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_step),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = zero_go ? S_FIX : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort)                     state_nxt = S_IDLE;
        else if (cnt == CNT_W'(1))     state_nxt = S_FIX;
      end
      S_FIX: begin
        busy = 1'b1;
        if (abort) state_nxt = S_IDLE;
        else       state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (accept) state_nxt = zero_go ? S_FIX : S_RUN;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign fix-up. A divide by zero overrides the iterated result; the signed
  // overflow case needs no special handling because |a|=2^(XLEN-1), |b|=1 and
  // equal signs leave the quotient as the most-negative value.
  always_comb begin
    prod   = res_neg ? -acc : acc;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = a_orig;
      end else begin
        res_lo = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        res_hi = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_orig  <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (!busy) begin
        if (mthi) hi <= a;
        if (mtlo) lo <= a;
      end
      if (accept) begin
        is_div  <= op_is_div(op);
        res_neg <= sgn_a ^ sgn_b;
        rem_neg <= sgn_a;
        a_orig  <= a;
        dz_q    <= op_is_div(op) && (b == '0);
        cnt     <= CNT_W'(XLEN);
        opnd    <= op_is_div(op) ? abs_b : abs_a;
        // A zero-skipped operation goes straight to FIX, where a zero
        // accumulator yields the correct product/quotient/remainder.
        acc     <= zero_go ? '0 : {{XLEN{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
      end else if (state == S_RUN) begin
        acc <= acc_step | {{(2*XLEN-1){1'b0}}, qbit};
        cnt <= cnt - CNT_W'(1);
      end
      if ((state == S_FIX) && !abort) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start, mthi, mtlo, abort;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b, hi, lo;
  logic            busy, done, div_by_zero;

  always #5 clk = ~clk;

  mdu_iterative dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .abort(abort),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: outstanding op deadline and architectural HI/LO.
  bit          pending = 0;
  int          done_at = 0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  bit          m_dz = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    longint     sp;
    logic [63:0] up;
    dz = 0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin sp = longint'($signed(x)) * longint'($signed(y)); {rh, rl} = sp; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; {rh, rl} = up; end
      default: begin
        if (y == 0) begin dz = 1; rl = '1; rh = x; end
        else if (o == 2'b11) begin rl = x / y; rh = x % y; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
        else begin rl = $signed(x) / $signed(y); rh = $signed(x) % $signed(y); end
      end
    endcase
  endfunction

  function automatic int op_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_ZERO_SKIP_EN
    if (x == 0 || y == 0) return 2;
`endif
    return XLEN + 2;
  endfunction

  // Model: advances at each clock edge from the inputs seen there.
  initial begin
    bit          bz, tdz;
    forever begin
      @(posedge clk);
      if (rst) begin
        pending = 0; m_hi = '0; m_lo = '0; m_dz = 0;
      end else begin
        bz = pending && (cyc < done_at);
        if (bz) begin
          if (abort) pending = 0;
          else if (cyc + 1 == done_at) begin m_hi = r_hi; m_lo = r_lo; end
        end else begin
          if (mthi) m_hi = a;
          if (mtlo) m_lo = a;
          if (start && !abort) begin
            ref_op(op, a, b, r_hi, r_lo, tdz);
            m_dz    = tdz;
            pending = 1;
            done_at = cyc + op_latency(a, b);
          end else begin
            pending = 0;
          end
        end
      end
      cyc++;
    end
  end

  // Compare: every cycle outside reset.
  initial begin
    bit eb, ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eb = pending && (cyc < done_at);
        ed = pending && (cyc == done_at);
        chk("busy", {31'b0, busy}, {31'b0, eb});
        chk("done", {31'b0, done}, {31'b0, ed});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (ed) chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
      end
    end
  end

  task automatic idle_in();
    start = 0; mthi = 0; mtlo = 0; abort = 0;
  endtask

  // Launch one op; optionally poke a stray start at cycle poke and abort at
  // cycle abort_at (relative to the launch cycle). lat = cycles to done, -1 if none.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input int abort_at, input int max_cyc, output int lat);
    @(posedge clk); #1;
    idle_in();
    start = 1; op = o; a = x; b = y;
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      start = (k == poke);
      if (k == poke) begin op = 2'b00; a = 32'd3; b = 32'd3; end
      abort = (k == abort_at);
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic write_hi(input logic [31:0] x);
    @(posedge clk); #1;
    idle_in(); mthi = 1; a = x;
    @(posedge clk); #1;
    mthi = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 20);
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int z_lat;

  initial begin
    rst = 1; op = 0; a = 0; b = 0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy_done", {30'b0, busy, done}, 32'h0);
    chk("reset_dz", {31'b0, div_by_zero}, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 60, lat);
    chk("mult_latency", 32'(lat), 32'd34);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b11, 32'd100, 32'd7, 5, 0, 60, lat);
    chk("divu_latency", 32'(lat), 32'd34);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 60, lat);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    z_lat = 34;
`ifdef MDU_ZERO_SKIP_EN
    z_lat = 2;
`endif
    run_op(2'b10, 32'd5, 32'd0, 0, 0, 60, lat);
    chk("dz_latency", 32'(lat), 32'(z_lat));
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", {31'b0, div_by_zero}, 32'd1);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 60, lat);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dz", {31'b0, div_by_zero}, 32'd0);

    write_hi(32'h1234);
    run_op(2'b01, 32'd9, 32'd9, 0, 10, 45, lat);
    chk("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
    chk("abort_hi", hi, 32'h1234);
    chk("abort_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of an operation clears HI/LO and returns to idle.
    write_hi(32'h0ABC);
    @(posedge clk); #1;
    start = 1; op = 2'b11; a = 32'd50; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);

    // Random traffic: back-to-back starts, stray starts while busy, aborts,
    // mthi/mtlo and occasional resets, all checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start = ($urandom % 100) < 30;
      abort = ($urandom % 100) < 1;
      mthi  = ($urandom % 100) < 5;
      mtlo  = ($urandom % 100) < 5;
      rst   = ($urandom % 1000) < 2;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
    end
    @(posedge clk); #1;
    idle_in();
    rst = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
